inst_fetch_cache: RTL

- Instruction-fetch front end sitting directly upstream of the memory controller's instruction port.
- Holds the fetch PC and a direct-mapped one-word-per-line instruction cache.
- On a miss it drives the inst_re/inst_addr/inst_busy handshake, fills the line and replays the lookup.
- It presents one instruction at a time to IF/ID with valid/stall flow control, and accepts branch redirects from EX.

---
 rtl/inst_fetch_cache_pkg.sv | 24 ++
 rtl/inst_fetch_cache_icache.sv | 53 +++++
 rtl/inst_fetch_cache.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/inst_fetch_cache_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_cache_pkg
//   Shared definitions for the instruction-fetch front end:
//     - fetch_state_t    : fetch FSM encoding (LOOKUP, REQ, WAIT)
//     - DEFAULT_RESET_PC : default PC loaded at reset
//     - NOP_INST         : canonical NOP (addi x0,x0,0) for bubble insertion
//     - word_align()     : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package inst_fetch_cache_pkg;

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,  // probe the cache at pc, present on hit
    ST_REQ    = 2'd1,  // inst_re raised, waiting for the controller to take it
    ST_WAIT   = 2'd2   // controller busy, fill when busy falls
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_cache_icache.sv
// -----------------------------------------------------------------------------
// icache_array
//   Direct-mapped, one-word-per-line storage: valid bit, tag and data per line.
//   Ports:
//     clk, rst                 : clock, asynchronous active-low reset
//     rd_index                 : combinational read index
//     rd_valid/rd_tag/rd_data  : contents of line rd_index
//     wr_en/wr_index/wr_tag/wr_data : synchronous line fill (sets valid)
// -----------------------------------------------------------------------------
module icache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; a cleared valid bit already hides
  // whatever they hold, and leaving them unreset lets them map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/inst_fetch_cache.sv
// -----------------------------------------------------------------------------
// inst_fetch_cache
//   Instruction-fetch front end: fetch PC, direct-mapped I-cache, miss handling
//   towards the memory controller, and a registered IF/ID output stage.
//   Ports:
//     clk, rst              : clock, asynchronous active-low reset
//     rdy                   : global ready, 0 freezes every register
//     stall_i               : IF/ID cannot accept, hold presented instruction
//     redirect_i/_pc_i      : branch redirect from EX and its target
//     inst_re/inst_addr     : fetch request to memory controller (registered)
//     inst_data/inst_busy   : controller response
//     if_valid/if_pc/if_inst: instruction presented to IF/ID (registered)
// -----------------------------------------------------------------------------
module inst_fetch_cache
  import inst_fetch_cache_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          INDEX_BITS = 6,
  parameter int          ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_re,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        inst_busy,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inst_re_q, inst_re_d;
  logic [31:0]  inst_addr_q, inst_addr_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic         fill_en;

  logic [INDEX_BITS-1:0] rd_index, wr_index;
  logic [TAG_BITS-1:0]   pc_tag, rd_tag, wr_tag;
  logic                  rd_valid, hit;
  logic [31:0]           rd_data;

  assign rd_index = pc_q[INDEX_BITS+1:2];
  assign pc_tag   = pc_q[ADDR_BITS-1:INDEX_BITS+2];
  assign hit      = rd_valid && (rd_tag == pc_tag);

  // The fill is addressed by the request in flight, not by pc, so a redirect
  // during REQ/WAIT cannot land inst_data in the wrong line.
  assign wr_index = inst_addr_q[INDEX_BITS+1:2];
  assign wr_tag   = inst_addr_q[ADDR_BITS-1:INDEX_BITS+2];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_icache_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en && rdy),
    .wr_index (wr_index),
    .wr_tag   (wr_tag),
    .wr_data  (inst_data)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_re_d   = inst_re_q;
    inst_addr_d = inst_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    fill_en     = 1'b0;

    unique case (state_q)
      ST_LOOKUP: begin
        if (redirect_i) begin
          // Redirect beats stall: the presented instruction is squashed.
          pc_d       = word_align(redirect_pc_i);
          if_valid_d = 1'b0;
        end else if (stall_i && if_valid_q) begin
          // Hold pc and the presented instruction (defaults already do so).
        end else if (hit) begin
          if_inst_d  = rd_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end else begin
          if_valid_d  = 1'b0;
          inst_re_d   = 1'b1;
          inst_addr_d = pc_q;
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        if (redirect_i) pc_d = word_align(redirect_pc_i);
        if (inst_busy) begin
          inst_re_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_i) pc_d = word_align(redirect_pc_i);
        if (!inst_busy) begin
          fill_en = 1'b1;
          state_d = ST_LOOKUP;
        end
      end

      default: state_d = ST_LOOKUP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOOKUP;
      pc_q        <= RESET_PC;
      inst_re_q   <= 1'b0;
      inst_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_re_q   <= inst_re_d;
      inst_addr_q <= inst_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign inst_re   = inst_re_q;
  assign inst_addr = inst_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

endmodule
